// File: rtl/bfloat16_div.sv
// ---------------------------------------------------------------------------
// bfloat16_div
//   Sequential bfloat16 divider, quotient = a / b. The mantissa quotient is
//   built by restoring division, one bit per clock. Number conventions match
//   the companion multiplier:
//     - the hidden bit is always 1 for nonzero operands;
//     - there are no subnormals;
//     - rounding is round-half-up.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a, b presented
//   in_ready   divider can accept (high only while idle)
//   a, b       dividend / divisor, bfloat16
//   out_valid  quotient valid, held until out_ready
//   out_ready  downstream accepts quotient
//   quotient   registered bfloat16 result, stable while out_valid
// ---------------------------------------------------------------------------
module bfloat16_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [9:0]  q_q;
  logic [8:0]  r_q;
  logic [7:0]  mb_q;
  logic [7:0]  ea_q;
  logic [7:0]  eb_q;
  logic        sign_q;
  logic        out_valid_q;
  logic [15:0] quotient_q;

  logic [16:0] spec_d;
  logic [15:0] norm_d;
  logic        r_ge;
  logic [8:0]  r_sub;
  logic [8:0]  r_d;
  logic [9:0]  q_d;

  // Special-case decode.
  //   Bit 16 flags a special result; bits 15:0 carry that result.
  //   The priority order matters:
  //     - 0/0 gives zero;
  //     - inf/0 gives inf.
  function automatic logic [16:0] classify_special(input logic [15:0] op_a,
                                                   input logic [15:0] op_b);
    logic        s;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;
    logic [16:0] res;
    s      = op_a[15] ^ op_b[15];
    a_zero = (op_a[14:0] == 15'd0);
    b_zero = (op_b[14:0] == 15'd0);
    a_inf  = (op_a[14:7] == 8'hFF);
    b_inf  = (op_b[14:7] == 8'hFF);
    if (a_zero)      res = {1'b1, 16'h0000};
    else if (b_zero) res = {1'b1, s, 8'hFF, 7'h00};
    else if (a_inf)  res = {1'b1, s, 8'hFF, 7'h00};
    else if (b_inf)  res = {1'b1, 16'h0000};
    else             res = {1'b0, 16'h0000};
    return res;
  endfunction

  // Normalise the 10-bit quotient, then round half-up and saturate.
  //   The quotient lies in (0.5, 2).
  //     - q[9] == 1: q[9] is the leading one.
  //     - q[9] == 0: q[8] is the leading one, so the exponent drops by one.
  //   The biased exponent is evaluated as a 10-bit signed value, so that
  //   both overflow and underflow are visible.
  function automatic logic [15:0] normalize_round(input logic       s,
                                                  input logic [7:0] ea,
                                                  input logic [7:0] eb,
                                                  input logic [9:0] q);
    logic [6:0]        mant;
    logic              rnd;
    logic              adj;
    logic [7:0]        mant_sum;
    logic signed [9:0] e;
    logic [15:0]       res;
    if (q[9]) begin
      mant = q[8:2];
      rnd  = q[1];
      adj  = 1'b0;
    end else begin
      mant = q[7:1];
      rnd  = q[0];
      adj  = 1'b1;
    end
    // A carry out of the mantissa leaves mant_sum[6:0] == 0 and bumps the exponent.
    mant_sum = {1'b0, mant} + {7'd0, rnd};
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
        - $signed({9'd0, adj}) + $signed({9'd0, mant_sum[7]});
    if (e >= 10'sd255)    res = {s, 8'hFF, 7'h00};
    else if (e <= 10'sd0) res = 16'h0000;
    else                  res = {s, e[7:0], mant_sum[6:0]};
    return res;
  endfunction

  // One restoring step. r < mb after a subtraction, so the shift cannot overflow.
  always_comb begin
    r_ge        = (r_q >= {1'b0, mb_q});
    r_sub       = r_ge ? (r_q - {1'b0, mb_q}) : r_q;
    r_d         = r_sub << 1;
    q_d         = q_q;
    q_d[cnt_q]  = r_ge;
    spec_d      = classify_special(a, b);
    norm_d      = normalize_round(sign_q, ea_q, eb_q, q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      q_q         <= 10'd0;
      r_q         <= 9'd0;
      mb_q        <= 8'd0;
      ea_q        <= 8'd0;
      eb_q        <= 8'd0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= 16'h0000;
    end else begin
      case (state_q)
        // Accept: specials finish immediately; everything else starts dividing.
        S_IDLE: begin
          if (in_valid) begin
            if (spec_d[16]) begin
              quotient_q  <= spec_d[15:0];
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              sign_q  <= a[15] ^ b[15];
              ea_q    <= a[14:7];
              eb_q    <= b[14:7];
              mb_q    <= {1'b1, b[6:0]};
              r_q     <= {2'b01, a[6:0]};
              q_q     <= 10'd0;
              cnt_q   <= 4'd9;
              state_q <= S_DIV;
            end
          end
        end
        // Mantissa division: quotient bits 9 down to 0.
        S_DIV: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == 4'd0) state_q <= S_NORM;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        // Normalise, round and pack into the output register.
        S_NORM: begin
          quotient_q  <= norm_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        // Hold the result until the downstream stage takes it.
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;

endmodule
